// File: rtl/hpdl_pkg.sv
// Shared types and helpers for the HPDL-1414 bus scheduler: digit geometry,
// FSM state encoding and the position-to-strobe mapping.
package hpdl_pkg;

  localparam int NUM_DIGITS     = 16;
  localparam int DIGITS_PER_DEV = 4;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SETUP,
    PULSE,
    HOLD
  } state_t;

  // One-hot-low write mask: only the device owning this position strobes.
  function automatic logic [3:0] pos_to_wr(input logic [3:0] pos);
    logic [3:0] mask;
    mask = 4'b1111;
    mask[pos[3:2]] = 1'b0;
    return mask;
  endfunction

endpackage

// File: rtl/hpdl_refresh_timer.sv
// Free-running refresh slot divider with a sticky pending flag; a terminal
// count while already pending is simply absorbed.
module hpdl_refresh_timer #(
  parameter int REFRESH_DIV = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic pending
);

  localparam int DW = $clog2(REFRESH_DIV);

  logic [DW-1:0] div_q, div_d;
  logic          pending_q, pending_d;
  logic          tc;

  always_comb begin
    tc        = (div_q == DW'(REFRESH_DIV - 1));
    div_d     = tc ? '0 : div_q + 1'b1;
    pending_d = pending_q;
    if (tc) pending_d = 1'b1;
    // Clear wins so a disabled scan never leaves a stale request behind.
    if (clr) pending_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q     <= '0;
      pending_q <= 1'b0;
    end else begin
      div_q     <= div_d;
      pending_q <= pending_d;
    end
  end

  assign pending = pending_q;

endmodule

// File: rtl/hpdl_bus_scheduler.sv
// Owns the HPDL-1414 bus: host writes win over the background refresh scan,
// and every write runs a programmable setup / pulse / hold sequence.
module hpdl_bus_scheduler
  import hpdl_pkg::*;
#(
  parameter int SETUP_CYC   = 2,
  parameter int PULSE_CYC   = 3,
  parameter int HOLD_CYC    = 2,
  parameter int REFRESH_DIV = 4096
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       req_valid,
  input  logic [3:0] req_pos,
  input  logic [6:0] req_char,
  output logic       req_ready,
  input  logic       refresh_en,
  output logic [3:0] rd_addr,
  input  logic [6:0] rd_data,
  output logic [6:0] HPDL_D,
  output logic [1:0] HPDL_A,
  output logic [3:0] HPDL_WR_N,
  output logic       busy
);

  localparam int CW = 8;
  localparam int PW = $clog2(NUM_DIGITS);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [3:0]    sel_q, sel_d;
  logic          refresh_q, refresh_d;
  logic [6:0]    d_q, d_d;
  logic [1:0]    a_q, a_d;
  logic [3:0]    wr_n_q, wr_n_d;
  logic [3:0]    rd_addr_q, rd_addr_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic          pending;
  logic          refresh_done;

  hpdl_refresh_timer #(
    .REFRESH_DIV(REFRESH_DIV)
  ) u_timer (
    .clk    (CLK),
    .rst_n  (RST_N),
    .clr    (~refresh_en | refresh_done),
    .pending(pending)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ptr_d        = ptr_q;
    sel_d        = sel_q;
    refresh_d    = refresh_q;
    d_d          = d_q;
    a_d          = a_q;
    wr_n_d       = wr_n_q;
    refresh_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          d_d       = req_char;
          a_d       = ~req_pos[1:0];
          sel_d     = req_pos;
          refresh_d = 1'b0;
          cnt_d     = '0;
          state_d   = SETUP;
        end else if (pending && refresh_en) begin
          refresh_d = 1'b1;
          state_d   = FETCH;
        end
      end
      FETCH: begin
        d_d     = rd_data;
        a_d     = ~ptr_q[1:0];
        sel_d   = ptr_q;
        cnt_d   = '0;
        state_d = SETUP;
      end
      SETUP: begin
        if (cnt_q == CW'(SETUP_CYC - 1)) begin
          cnt_d   = '0;
          wr_n_d  = pos_to_wr(sel_q);
          state_d = PULSE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PULSE: begin
        if (cnt_q == CW'(PULSE_CYC - 1)) begin
          cnt_d   = '0;
          wr_n_d  = 4'b1111;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (cnt_q == CW'(HOLD_CYC - 1)) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (refresh_q) begin
            refresh_done = 1'b1;
            ptr_d        = ptr_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // The read address tracks the pointer continuously, so rd_data is already
    // settled when FETCH samples it despite the one-cycle buffer latency.
    rd_addr_d = ptr_d;
    ready_d   = (state_d == IDLE);
    busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ptr_q     <= '0;
      sel_q     <= '0;
      refresh_q <= 1'b0;
      d_q       <= '0;
      a_q       <= 2'b11;
      wr_n_q    <= 4'b1111;
      rd_addr_q <= '0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      sel_q     <= sel_d;
      refresh_q <= refresh_d;
      d_q       <= d_d;
      a_q       <= a_d;
      wr_n_q    <= wr_n_d;
      rd_addr_q <= rd_addr_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
    end
  end

  assign HPDL_D    = d_q;
  assign HPDL_A    = a_q;
  assign HPDL_WR_N = wr_n_q;
  assign rd_addr   = rd_addr_q;
  assign req_ready = ready_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_hpdl_bus_scheduler.sv
// Randomized self-checking bench for hpdl_bus_scheduler: observed write pulses
// are compared against a transaction-level model of host and refresh writes.
module tb_hpdl_bus_scheduler;

  localparam int SETUP_CYC    = 2;
  localparam int PULSE_CYC    = 3;
  localparam int HOLD_CYC     = 2;
  localparam int REFRESH_DIV  = 64;
  localparam int WRITE_PERIOD = SETUP_CYC + PULSE_CYC + HOLD_CYC + 1;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       req_valid = 1'b0;
  logic [3:0] req_pos = '0;
  logic [6:0] req_char = '0;
  logic       req_ready;
  logic       refresh_en = 1'b0;
  logic [3:0] rd_addr;
  logic [6:0] rd_data = '0;
  logic [6:0] HPDL_D;
  logic [1:0] HPDL_A;
  logic [3:0] HPDL_WR_N;
  logic       busy;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [6:0] d;
    logic [1:0] a;
    logic [3:0] wr;
    int         width;
    int         setup;
    bit         hold_ok;
    int         t_fall;
  } pulse_t;

  typedef struct {
    logic [3:0] pos;
    logic [6:0] ch;
    int         t;
  } host_t;

  typedef struct {
    logic [3:0] pos;
    logic [6:0] d;
    logic [1:0] a;
    logic [3:0] wr;
    bit         host;
  } exp_t;

  logic [6:0] buf_mem [16];
  pulse_t     pq[$];
  host_t      hostq[$];
  int         acc_log[$];
  int         exp_ptr = 0;
  int         cyc = 0;
  int         wr_low_cnt = 0;

  hpdl_bus_scheduler #(
    .SETUP_CYC  (SETUP_CYC),
    .PULSE_CYC  (PULSE_CYC),
    .HOLD_CYC   (HOLD_CYC),
    .REFRESH_DIV(REFRESH_DIV)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .req_valid (req_valid),
    .req_pos   (req_pos),
    .req_char  (req_char),
    .req_ready (req_ready),
    .refresh_en(refresh_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .HPDL_D    (HPDL_D),
    .HPDL_A    (HPDL_A),
    .HPDL_WR_N (HPDL_WR_N),
    .busy      (busy)
  );

  initial forever #5 CLK = ~CLK;

  // Character buffer with a registered read port.
  always @(posedge CLK) rd_data <= buf_mem[rd_addr];

  // Bus monitor: records handshakes and complete write pulses, sampled on negedge.
  initial begin
    pulse_t     cur;
    bit         in_pulse;
    int         hold_left;
    int         stable;
    logic [8:0] da, prev_da;
    host_t      h;
    in_pulse = 0; hold_left = 0; stable = 0; prev_da = '0;
    cur = '{d: '0, a: '0, wr: '0, width: 0, setup: 0, hold_ok: 0, t_fall: 0};
    forever begin
      @(negedge CLK);
      cyc++;
      da = {HPDL_D, HPDL_A};
      if (!RST_N) begin
        in_pulse = 0;
        hold_left = 0;
        stable = 0;
      end else begin
        if (req_valid && req_ready) begin
          h.pos = req_pos; h.ch = req_char; h.t = cyc;
          hostq.push_back(h);
          acc_log.push_back(cyc);
        end
        if (HPDL_WR_N != 4'hF) wr_low_cnt++;
        if (da != prev_da) stable = 0; else stable++;
        if (in_pulse) begin
          if (HPDL_WR_N == 4'hF) begin
            in_pulse = 0;
            hold_left = HOLD_CYC;
          end else begin
            cur.width++;
            if (HPDL_WR_N !== cur.wr) cur.hold_ok = 0;
          end
          if (da != {cur.d, cur.a}) cur.hold_ok = 0;
        end else if (HPDL_WR_N != 4'hF) begin
          cur.d = HPDL_D; cur.a = HPDL_A; cur.wr = HPDL_WR_N;
          cur.width = 1; cur.setup = stable; cur.hold_ok = 1; cur.t_fall = cyc;
          in_pulse = 1;
        end
        if (hold_left > 0) begin
          if (da != {cur.d, cur.a}) cur.hold_ok = 0;
          hold_left--;
          if (hold_left == 0) pq.push_back(cur);
        end
      end
      prev_da = da;
    end
  end

  // Reference model: the next bus write is the oldest accepted host request
  // if one was accepted before this pulse, otherwise the next refresh digit.
  function automatic exp_t model_next(input int t_fall);
    exp_t  e;
    host_t h;
    if (hostq.size() > 0 && hostq[0].t < t_fall) begin
      h = hostq.pop_front();
      e.pos = h.pos; e.d = h.ch; e.host = 1;
    end else begin
      e.pos = 4'(exp_ptr); e.d = buf_mem[exp_ptr]; e.host = 0;
      exp_ptr = (exp_ptr + 1) % 16;
    end
    e.a  = ~e.pos[1:0];
    e.wr = ~(4'b0001 << e.pos[3:2]);
    return e;
  endfunction

  task automatic wait_pulses(input int n, input int bound, output bit ok);
    int k = 0;
    while (pq.size() < n && k < bound) begin
      @(negedge CLK);
      k++;
    end
    ok = (pq.size() >= n);
  endtask

  // Drives random host requests; req_valid stays high until each is accepted.
  task automatic host_stream(input int n_acc, input int bound, input int idle_pct, output int got);
    bit acc;
    got = 0;
    for (int c = 0; c < bound && got < n_acc; c++) begin
      @(negedge CLK);
      acc = req_valid && req_ready;
      @(posedge CLK);
      #1;
      if (acc) got++;
      if (acc || !req_valid) begin
        if (got < n_acc && $urandom_range(99) >= idle_pct) begin
          req_valid = 1'b1;
          req_pos   = 4'($urandom);
          req_char  = 7'($urandom);
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    req_valid = 1'b0;
  endtask

  task automatic test_reset;
    int low0;
    repeat (3) @(negedge CLK);
    checks++;
    if (HPDL_WR_N !== 4'b1111) begin failures++; $display("FAIL reset_wr_n: got %b want 1111", HPDL_WR_N); end
    checks++;
    if (HPDL_A !== 2'b11) begin failures++; $display("FAIL reset_a: got %b want 11", HPDL_A); end
    checks++;
    if (HPDL_D !== 7'h00) begin failures++; $display("FAIL reset_d: got %h want 00", HPDL_D); end
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL reset_handshake: got ready=%b busy=%b want 1 0", req_ready, busy);
    end
    checks++;
    if (rd_addr !== 4'd0) begin failures++; $display("FAIL reset_rd_addr: got %0d want 0", rd_addr); end
    #2 RST_N = 1'b1;
    low0 = wr_low_cnt;
    repeat (10000) @(negedge CLK);
    checks++;
    if (wr_low_cnt != low0 || pq.size() != 0) begin
      failures++; $display("FAIL reset_quiet: got %0d strobe samples %0d pulses want 0", wr_low_cnt - low0, pq.size());
    end
    $display("test_reset: idle bus checked for 10000 cycles");
  endtask

  task automatic test_host_write;
    logic [3:0] want_wr;
    bit         ok;
    pulse_t     p;
    exp_t       e;
    @(posedge CLK);
    #1;
    req_valid = 1'b1; req_pos = 4'd6; req_char = 7'h41;
    @(negedge CLK);
    checks++;
    if (req_ready !== 1'b1) begin failures++; $display("FAIL host_ready_idle: got %b want 1", req_ready); end
    @(posedge CLK);
    #1 req_valid = 1'b0;
    for (int k = 0; k <= 7; k++) begin
      @(negedge CLK);
      want_wr = (k >= SETUP_CYC && k < SETUP_CYC + PULSE_CYC) ? 4'b1101 : 4'b1111;
      checks++;
      if (HPDL_WR_N !== want_wr) begin failures++; $display("FAIL host_wr_T+%0d: got %b want %b", k, HPDL_WR_N, want_wr); end
      checks++;
      if (req_ready !== (k == 7) || busy !== (k != 7)) begin
        failures++; $display("FAIL host_ready_T+%0d: got ready=%b busy=%b want %b %b", k, req_ready, busy, k == 7, k != 7);
      end
      if (k < 7) begin
        checks++;
        if (HPDL_D !== 7'h41 || HPDL_A !== 2'b01) begin
          failures++; $display("FAIL host_bus_T+%0d: got d=%h a=%b want 41 01", k, HPDL_D, HPDL_A);
        end
      end
    end
    wait_pulses(1, 20, ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL host_pulse_seen: got 0 pulses want 1");
    end else begin
      p = pq.pop_front();
      e = model_next(p.t_fall);
      checks++;
      if (p.d !== e.d || p.a !== e.a || p.wr !== e.wr || !e.host) begin
        failures++; $display("FAIL host_pulse: got d=%h a=%b wr=%b want d=%h a=%b wr=%b", p.d, p.a, p.wr, e.d, e.a, e.wr);
      end
      checks++;
      if (p.width != PULSE_CYC || !p.hold_ok) begin
        failures++; $display("FAIL host_timing: got width=%0d hold_ok=%0d want %0d 1", p.width, p.hold_ok, PULSE_CYC);
      end
    end
    $display("test_host_write: pos=6 char=41 checked");
  endtask

  task automatic test_refresh_scan;
    bit     ok;
    pulse_t p;
    exp_t   e;
    int     prev_t = 0;
    refresh_en = 1'b1;
    wait_pulses(17, 17 * REFRESH_DIV + 200, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL scan_count: got %0d pulses want 17", pq.size()); end
    for (int i = 0; i < 17 && pq.size() > 0; i++) begin
      p = pq.pop_front();
      e = model_next(p.t_fall);
      checks++;
      if (e.host || e.pos !== 4'(i % 16) || p.d !== e.d || p.a !== e.a || p.wr !== e.wr) begin
        failures++;
        $display("FAIL scan_pulse%0d: got d=%h a=%b wr=%b want ptr=%0d d=%h a=%b wr=%b", i, p.d, p.a, p.wr, e.pos, e.d, e.a, e.wr);
      end
      checks++;
      if (p.width != PULSE_CYC || p.setup < SETUP_CYC || !p.hold_ok) begin
        failures++; $display("FAIL scan_timing%0d: got width=%0d setup=%0d hold_ok=%0d", i, p.width, p.setup, p.hold_ok);
      end
      if (i > 0) begin
        checks++;
        if (p.t_fall - prev_t != REFRESH_DIV) begin
          failures++; $display("FAIL scan_spacing%0d: got %0d want %0d", i, p.t_fall - prev_t, REFRESH_DIV);
        end
      end
      prev_t = p.t_fall;
      $display("scan write %0d: ptr=%0d d=%h wr=%b", i, e.pos, p.d, p.wr);
    end
    refresh_en = 1'b0;
    repeat (20) @(negedge CLK);
  endtask

  task automatic test_back_to_back;
    int     got;
    bit     ok;
    pulse_t p;
    exp_t   e;
    acc_log.delete();
    host_stream(12, 400, 0, got);
    checks++;
    if (got != 12) begin failures++; $display("FAIL b2b_accepts: got %0d want 12", got); end
    for (int i = 1; i < acc_log.size(); i++) begin
      checks++;
      if (acc_log[i] - acc_log[i-1] != WRITE_PERIOD) begin
        failures++; $display("FAIL b2b_period%0d: got %0d want %0d", i, acc_log[i] - acc_log[i-1], WRITE_PERIOD);
      end
    end
    wait_pulses(12, 100, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL b2b_pulses: got %0d want 12", pq.size()); end
    while (pq.size() > 0) begin
      p = pq.pop_front();
      e = model_next(p.t_fall);
      checks++;
      if (!e.host || p.d !== e.d || p.a !== e.a || p.wr !== e.wr || p.width != PULSE_CYC
          || p.setup < SETUP_CYC || !p.hold_ok) begin
        failures++;
        $display("FAIL b2b_pulse: got d=%h a=%b wr=%b w=%0d s=%0d h=%0d want d=%h a=%b wr=%b", p.d, p.a, p.wr,
                 p.width, p.setup, p.hold_ok, e.d, e.a, e.wr);
      end
      $display("b2b write: pos=%0d d=%h wr=%b", e.pos, p.d, p.wr);
    end
  endtask

  task automatic test_collision;
    int     got;
    bit     ok;
    pulse_t p;
    exp_t   e;
    int     last_host_t = 0;
    int     ptr0;
    ptr0 = exp_ptr;
    refresh_en = 1'b1;
    // Hosts occupy the bus across several terminal counts, so a refresh is
    // left pending and must follow the last host write straight away.
    host_stream(20, 400, 0, got);
    wait_pulses(21, 200, ok);
    checks++;
    if (!ok || got != 20) begin failures++; $display("FAIL coll_count: got %0d pulses %0d accepts want 21 20", pq.size(), got); end
    for (int i = 0; i < 21 && pq.size() > 0; i++) begin
      p = pq.pop_front();
      e = model_next(p.t_fall);
      checks++;
      if (e.host != (i < 20) || p.d !== e.d || p.a !== e.a || p.wr !== e.wr || !p.hold_ok) begin
        failures++; $display("FAIL coll_pulse%0d: got d=%h a=%b wr=%b want host=%0d d=%h a=%b wr=%b", i, p.d, p.a, p.wr,
                             i < 20, e.d, e.a, e.wr);
      end
      if (i == 20) begin
        checks++;
        if (p.t_fall - last_host_t != WRITE_PERIOD + 1 || e.pos != 4'(ptr0)) begin
          failures++; $display("FAIL coll_refresh: got gap=%0d ptr=%0d want gap=%0d ptr=%0d", p.t_fall - last_host_t, e.pos,
                               WRITE_PERIOD + 1, ptr0);
        end
      end
      last_host_t = p.t_fall;
      $display("collision write %0d: host=%0d pos=%0d d=%h", i, e.host, e.pos, p.d);
    end
    refresh_en = 1'b0;
    repeat (20) @(negedge CLK);
    checks++;
    if (pq.size() != 0) begin failures++; $display("FAIL coll_extra: got %0d extra pulses want 0", pq.size()); end
  endtask

  task automatic test_random;
    int     got;
    int     n = 0;
    pulse_t p;
    exp_t   e;
    refresh_en = 1'b1;
    host_stream(1000, 3000, 70, got);
    refresh_en = 1'b0;
    repeat (30) @(negedge CLK);
    while (pq.size() > 0) begin
      p = pq.pop_front();
      e = model_next(p.t_fall);
      checks++;
      if (p.d !== e.d || p.a !== e.a || p.wr !== e.wr || p.width != PULSE_CYC || p.setup < SETUP_CYC || !p.hold_ok) begin
        failures++;
        $display("FAIL rand_pulse%0d: got d=%h a=%b wr=%b w=%0d s=%0d h=%0d want host=%0d d=%h a=%b wr=%b", n, p.d, p.a,
                 p.wr, p.width, p.setup, p.hold_ok, e.host, e.d, e.a, e.wr);
      end
      $display("random write %0d: host=%0d pos=%0d d=%h", n, e.host, e.pos, p.d);
      n++;
    end
    checks++;
    if (hostq.size() != 0) begin failures++; $display("FAIL rand_unserved: got %0d host requests left want 0", hostq.size()); end
  endtask

  task automatic test_reset_mid_pulse;
    int     k = 0;
    int     low0;
    bit     ok;
    pulse_t p;
    exp_t   e;
    @(posedge CLK);
    #1;
    req_valid = 1'b1; req_pos = 4'($urandom); req_char = 7'($urandom);
    while (HPDL_WR_N == 4'hF && k < 20) begin
      @(negedge CLK);
      k++;
      if (req_valid && req_ready) begin
        @(posedge CLK);
        #1 req_valid = 1'b0;
      end
    end
    checks++;
    if (HPDL_WR_N == 4'hF) begin failures++; $display("FAIL mid_reset_strobe: got no strobe within 20 cycles"); end
    #2 RST_N = 1'b0;
    #1;
    checks++;
    if (HPDL_WR_N !== 4'b1111 || HPDL_A !== 2'b11 || HPDL_D !== 7'h00) begin
      failures++; $display("FAIL mid_reset_bus: got wr=%b a=%b d=%h want 1111 11 00", HPDL_WR_N, HPDL_A, HPDL_D);
    end
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || rd_addr !== 4'd0) begin
      failures++; $display("FAIL mid_reset_state: got ready=%b busy=%b rd_addr=%0d want 1 0 0", req_ready, busy, rd_addr);
    end
    req_valid = 1'b0;
    repeat (2) @(negedge CLK);
    #2 RST_N = 1'b1;
    pq.delete();
    hostq.delete();
    exp_ptr = 0;
    low0 = wr_low_cnt;
    repeat (20) @(negedge CLK);
    checks++;
    if (wr_low_cnt != low0 || pq.size() != 0 || req_ready !== 1'b1) begin
      failures++; $display("FAIL mid_reset_after: got %0d strobe samples ready=%b want 0 1", wr_low_cnt - low0, req_ready);
    end
    refresh_en = 1'b1;
    wait_pulses(1, 3 * REFRESH_DIV, ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL mid_reset_refresh: got 0 pulses want 1");
    end else begin
      p = pq.pop_front();
      e = model_next(p.t_fall);
      checks++;
      if (e.pos != 4'd0 || p.d !== e.d || p.a !== e.a || p.wr !== e.wr) begin
        failures++; $display("FAIL mid_reset_ptr: got d=%h a=%b wr=%b want d=%h a=%b wr=%b", p.d, p.a, p.wr, e.d, e.a, e.wr);
      end
      $display("post-reset refresh write: ptr=%0d d=%h wr=%b", e.pos, p.d, p.wr);
    end
    refresh_en = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) buf_mem[i] = 7'(8'h30 + i);
    test_reset;
    test_host_write;
    test_refresh_scan;
    test_back_to_back;
    test_collision;
    for (int i = 0; i < 16; i++) buf_mem[i] = 7'($urandom);
    test_random;
    test_reset_mid_pulse;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
